// File: rtl/axi_lite_mayo_pkg.sv
// Shared constants for the MAYO keygen AXI4-Lite register bank: register map
// indices, CTRL/STATUS bit positions, the ID word and AXI response codes.
package axi_lite_mayo_pkg;

   localparam int IDX_CTRL    = 0;
   localparam int IDX_STATUS  = 1;
   localparam int IDX_ID      = 2;
   localparam int IDX_INFO    = 3;
   localparam int IDX_WR_BASE = 4;

   localparam int CTRL_START    = 0;
   localparam int CTRL_SOFT_RST = 1;
   localparam int CTRL_IRQ_EN   = 2;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_START_ERR = 2;

   localparam logic [31:0] ID_VALUE = 32'h4D41_594F;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Which region of the map a word index lands in; shared by both paths so
   // write and read decode can never disagree.
   typedef enum logic [2:0] {
      REG_CTRL,
      REG_STATUS,
      REG_ID,
      REG_INFO,
      REG_PARAM,
      REG_RESULT,
      REG_UNMAPPED
   } regKind_e;

   // Parameter registers follow the four fixed words, result registers follow
   // the parameter registers, and everything above that is a hole.
   function automatic regKind_e decodeIdx(input int idx, input int nWr, input int nRd);
      regKind_e kind;
      if (idx == IDX_CTRL)                          kind = REG_CTRL;
      else if (idx == IDX_STATUS)                   kind = REG_STATUS;
      else if (idx == IDX_ID)                       kind = REG_ID;
      else if (idx == IDX_INFO)                     kind = REG_INFO;
      else if (idx < IDX_WR_BASE + nWr)             kind = REG_PARAM;
      else if (idx < IDX_WR_BASE + nWr + nRd)       kind = REG_RESULT;
      else                                          kind = REG_UNMAPPED;
      return kind;
   endfunction

endpackage

// File: rtl/axi_lite_mayo_wr_ctrl.sv
// AXI4-Lite write front end: captures AW and W independently, issues a
// one-cycle commit strobe to the register file and runs the B channel.
module axi_lite_mayo_wr_ctrl
   import axi_lite_mayo_pkg::*;
#(
   parameter int DW          = 32,
   parameter int ADDR_W      = 7,
   parameter int NUM_WR_REGS = 8,
   parameter int NUM_RD_REGS = 8,
   parameter int IDX_W       = ADDR_W - $clog2(DW/8)
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic [ADDR_W-1:0] S_AXI_AWADDR,
   input  logic [2:0]        S_AXI_AWPROT,
   input  logic              S_AXI_AWVALID,
   output logic              S_AXI_AWREADY,
   input  logic [DW-1:0]     S_AXI_WDATA,
   input  logic [DW/8-1:0]   S_AXI_WSTRB,
   input  logic              S_AXI_WVALID,
   output logic              S_AXI_WREADY,
   output logic [1:0]        S_AXI_BRESP,
   output logic              S_AXI_BVALID,
   input  logic              S_AXI_BREADY,
   output logic              commit,
   output logic [IDX_W-1:0]  word_idx,
   output logic [DW-1:0]     wdata,
   output logic [DW/8-1:0]   wstrb
);

   localparam int BYTE_BITS = $clog2(DW/8);

   logic              readyEn;
   logic              awHeld;
   logic              wHeld;
   logic              bValid;
   logic              commitPulse;
   logic [1:0]        bResp;
   logic [ADDR_W-1:0] awAddr;
   logic [DW-1:0]     wDataHeld;
   logic [DW/8-1:0]   wStrbHeld;
   logic              awFire;
   logic              wFire;
   logic              awHeldNext;
   logic              wHeldNext;
   logic [ADDR_W-1:0] addrNext;
   regKind_e          kindNext;
   logic              unusedBits;

   assign S_AXI_AWREADY = readyEn && !awHeld && !bValid;
   assign S_AXI_WREADY  = readyEn && !wHeld && !bValid;
   assign S_AXI_BVALID  = bValid;
   assign S_AXI_BRESP   = bResp;
   assign commit        = commitPulse;
   assign word_idx      = awAddr[ADDR_W-1:BYTE_BITS];
   assign wdata         = wDataHeld;
   assign wstrb         = wStrbHeld;
   assign unusedBits    = ^{S_AXI_AWPROT, awAddr[BYTE_BITS-1:0]};

   // Look one edge ahead: the commit fires on the edge where the second of AW
   // and W lands, so the response code must decode the address that will be
   // held after that edge, whichever channel happened to arrive last.
   always_comb begin
      awFire     = S_AXI_AWVALID && S_AXI_AWREADY;
      wFire      = S_AXI_WVALID && S_AXI_WREADY;
      awHeldNext = awHeld || awFire;
      wHeldNext  = wHeld || wFire;
      addrNext   = awHeld ? awAddr : S_AXI_AWADDR;
      kindNext   = decodeIdx(int'(addrNext[ADDR_W-1:BYTE_BITS]), NUM_WR_REGS, NUM_RD_REGS);
   end

   // Holding registers for each channel plus the B response. READY stays low
   // until the first clock after reset so nothing is accepted while the bank
   // is still coming out of reset. The held address and data stay put through
   // the response so the register file can use them during the commit cycle.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         readyEn     <= 1'b0;
         awHeld      <= 1'b0;
         wHeld       <= 1'b0;
         bValid      <= 1'b0;
         commitPulse <= 1'b0;
         bResp       <= RESP_OKAY;
         awAddr      <= '0;
         wDataHeld   <= '0;
         wStrbHeld   <= '0;
      end else begin
         readyEn     <= 1'b1;
         commitPulse <= 1'b0;
         if (awFire) begin
            awHeld <= 1'b1;
            awAddr <= S_AXI_AWADDR;
         end
         if (wFire) begin
            wHeld     <= 1'b1;
            wDataHeld <= S_AXI_WDATA;
            wStrbHeld <= S_AXI_WSTRB;
         end
         if (!bValid && awHeldNext && wHeldNext) begin
            commitPulse <= 1'b1;
            bValid      <= 1'b1;
            bResp       <= (kindNext == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
         end
         if (bValid && S_AXI_BREADY) begin
            bValid <= 1'b0;
            awHeld <= 1'b0;
            wHeld  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi_lite_mayo_regbank.sv
// AXI4-Lite register bank in front of the MAYO keygen core: control/status,
// RW parameter registers driven to the core and RO result registers from it.
module axi_lite_mayo_regbank
   import axi_lite_mayo_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int NUM_WR_REGS        = 8,
   parameter int NUM_RD_REGS        = 8,
   parameter int C_S_AXI_ADDR_WIDTH = $clog2((4 + NUM_WR_REGS + NUM_RD_REGS) * C_S_AXI_DATA_WIDTH / 8)
) (
   input  logic                                  ACLK,
   input  logic                                  ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
   input  logic [2:0]                            S_AXI_AWPROT,
   input  logic                                  S_AXI_AWVALID,
   output logic                                  S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
   input  logic                                  S_AXI_WVALID,
   output logic                                  S_AXI_WREADY,
   output logic [1:0]                            S_AXI_BRESP,
   output logic                                  S_AXI_BVALID,
   input  logic                                  S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
   input  logic [2:0]                            S_AXI_ARPROT,
   input  logic                                  S_AXI_ARVALID,
   output logic                                  S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
   output logic [1:0]                            S_AXI_RRESP,
   output logic                                  S_AXI_RVALID,
   input  logic                                  S_AXI_RREADY,
   output logic                                  core_start,
   output logic                                  core_soft_rst,
   input  logic                                  core_busy,
   input  logic                                  core_done,
   output logic [NUM_WR_REGS*C_S_AXI_DATA_WIDTH-1:0] wr_regs_o,
   input  logic [NUM_RD_REGS*C_S_AXI_DATA_WIDTH-1:0] rd_regs_i,
   output logic                                  irq
);

   localparam int DW        = C_S_AXI_DATA_WIDTH;
   localparam int ADDR_W    = C_S_AXI_ADDR_WIDTH;
   localparam int BYTE_BITS = $clog2(DW/8);
   localparam int IDX_W     = ADDR_W - BYTE_BITS;

   logic                             commit;
   logic [IDX_W-1:0]                 wordIdx;
   logic [DW-1:0]                    wrData;
   logic [DW/8-1:0]                  wrStrb;
   regKind_e                         wrKind;
   logic                             ctrlWrite;
   logic                             statusWrite;
   logic                             startReq;
   logic                             doneClr;
   logic                             errClr;
   logic [NUM_WR_REGS-1:0][DW-1:0]   paramRegs;
   logic [NUM_RD_REGS-1:0][DW-1:0]   resultRegs;
   logic                             irqEn;
   logic                             doneFlag;
   logic                             startErr;
   logic                             startPulse;
   logic                             softRstPulse;
   logic                             irqReg;
   logic                             rdReadyEn;
   logic                             rValid;
   logic [DW-1:0]                    rData;
   logic [1:0]                       rResp;
   logic [IDX_W-1:0]                 rdIdx;
   regKind_e                         rdKind;
   logic [DW-1:0]                    readWord;
   logic                             arFire;
   logic                             unusedBits;

   axi_lite_mayo_wr_ctrl #(
      .DW          (DW),
      .ADDR_W      (ADDR_W),
      .NUM_WR_REGS (NUM_WR_REGS),
      .NUM_RD_REGS (NUM_RD_REGS),
      .IDX_W       (IDX_W)
   ) wrCtrl (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .commit        (commit),
      .word_idx      (wordIdx),
      .wdata         (wrData),
      .wstrb         (wrStrb)
   );

   assign wr_regs_o     = paramRegs;
   assign resultRegs    = rd_regs_i;
   assign core_start    = startPulse;
   assign core_soft_rst = softRstPulse;
   assign irq           = irqReg;
   assign S_AXI_ARREADY = rdReadyEn && !rValid;
   assign S_AXI_RVALID  = rValid;
   assign S_AXI_RDATA   = rData;
   assign S_AXI_RRESP   = rResp;
   assign unusedBits    = ^{S_AXI_ARPROT, S_AXI_ARADDR[BYTE_BITS-1:0]};

   // Decode the committed write into the few control-side events it can
   // cause. Pulse and W1C bits all live in byte 0, so byte 0's strobe gates them.
   always_comb begin
      wrKind      = decodeIdx(int'(wordIdx), NUM_WR_REGS, NUM_RD_REGS);
      ctrlWrite   = commit && (wrKind == REG_CTRL) && wrStrb[0];
      statusWrite = commit && (wrKind == REG_STATUS) && wrStrb[0];
      startReq    = ctrlWrite && wrData[CTRL_START];
      doneClr     = statusWrite && wrData[STAT_DONE];
      errClr      = statusWrite && wrData[STAT_START_ERR];
   end

   // Control and status state. A START while the core is busy is refused and
   // flagged instead of pulsed. The sticky bits are written so that a hardware
   // set always beats a software clear arriving on the same edge, so an event
   // can never be lost to a racing W1C. The interrupt is a registered copy of
   // IRQ_EN & DONE to keep it glitch-free on its way to the PS.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         irqEn        <= 1'b0;
         doneFlag     <= 1'b0;
         startErr     <= 1'b0;
         startPulse   <= 1'b0;
         softRstPulse <= 1'b0;
         irqReg       <= 1'b0;
      end else begin
         startPulse   <= startReq && !core_busy;
         softRstPulse <= ctrlWrite && wrData[CTRL_SOFT_RST];
         if (ctrlWrite) begin
            irqEn <= wrData[CTRL_IRQ_EN];
         end
         doneFlag <= (doneFlag && !doneClr) || core_done;
         startErr <= (startErr && !errClr) || (startReq && core_busy);
         irqReg   <= irqEn && doneFlag;
      end
   end

   // Parameter registers take committed data byte by byte under WSTRB; writes
   // to any other region leave them untouched.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         paramRegs <= '0;
      end else if (commit && (wrKind == REG_PARAM)) begin
         for (int i = 0; i < NUM_WR_REGS; i++) begin
            if (int'(wordIdx) == IDX_WR_BASE + i) begin
               for (int b = 0; b < DW/8; b++) begin
                  if (wrStrb[b]) begin
                     paramRegs[i][b*8 +: 8] <= wrData[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // Read mux driven straight from ARADDR so the word, including a snapshot
   // of the core results, is captured on the AR handshake edge itself.
   always_comb begin
      rdIdx    = S_AXI_ARADDR[ADDR_W-1:BYTE_BITS];
      rdKind   = decodeIdx(int'(rdIdx), NUM_WR_REGS, NUM_RD_REGS);
      arFire   = S_AXI_ARVALID && S_AXI_ARREADY;
      readWord = '0;
      case (rdKind)
         REG_CTRL: begin
            readWord[CTRL_IRQ_EN] = irqEn;
         end
         REG_STATUS: begin
            readWord[STAT_BUSY]      = core_busy;
            readWord[STAT_DONE]      = doneFlag;
            readWord[STAT_START_ERR] = startErr;
         end
         REG_ID: begin
            readWord[31:0] = ID_VALUE;
         end
         REG_INFO: begin
            readWord[15:0] = {8'(NUM_RD_REGS), 8'(NUM_WR_REGS)};
         end
         REG_PARAM: begin
            for (int i = 0; i < NUM_WR_REGS; i++) begin
               if (int'(rdIdx) == IDX_WR_BASE + i) readWord = paramRegs[i];
            end
         end
         REG_RESULT: begin
            for (int i = 0; i < NUM_RD_REGS; i++) begin
               if (int'(rdIdx) == IDX_WR_BASE + NUM_WR_REGS + i) readWord = resultRegs[i];
            end
         end
         default: begin
            readWord = '0;
         end
      endcase
   end

   // R channel: one read in flight, data and response registered on the AR
   // handshake and held unchanged until the master takes them.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rdReadyEn <= 1'b0;
         rValid    <= 1'b0;
         rData     <= '0;
         rResp     <= RESP_OKAY;
      end else begin
         rdReadyEn <= 1'b1;
         if (arFire) begin
            rValid <= 1'b1;
            rData  <= readWord;
            rResp  <= (rdKind == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
         end else if (rValid && S_AXI_RREADY) begin
            rValid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/axi_lite_mayo_regbank.md
Name: axi_lite_mayo_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed four-register S00_AXI slave.
- Fronts the MAYO keygen core with a control/status block, NUM_WR_REGS RW parameter registers, and NUM_RD_REGS RO result registers.
- Adds byte strobes, independent AW/W acceptance, start/done handshake, sticky W1C status, interrupt, and SLVERR decode.
- Sits between the PS interconnect and the keygen core inside the block-design wrapper.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; 32 or 64.
- NUM_WR_REGS, 8, RW parameter registers driven to the core; 1..64.
- NUM_RD_REGS, 8, RO result registers sampled from the core; 1..64.
- C_S_AXI_ADDR_WIDTH, derived = clog2((4+NUM_WR_REGS+NUM_RD_REGS)*DW/8) rounded up; byte address width.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DW/DW/8/1/1  write data channel
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read address channel
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DW/2/1/1  read data channel
- core_start  out  1  one-cycle start pulse
- core_soft_rst  out  1  one-cycle core reset pulse
- core_busy  in  1  core running
- core_done  in  1  one-cycle completion pulse
- wr_regs_o  out  NUM_WR_REGS*DW  parameter registers, flat, reg 0 at LSBs
- rd_regs_i  in  NUM_RD_REGS*DW  result registers, flat
- irq  out  1  level interrupt

Behaviour:
- Register map, word index = addr >> clog2(DW/8):
  - idx0 CTRL: bit0 START, write-1 pulse, reads 0; bit1 SOFT_RST, write-1 pulse, reads 0; bit2 IRQ_EN, RW.
  - idx1 STATUS: bit0 BUSY (RO, live core_busy); bit1 DONE (sticky, W1C); bit2 START_ERR (sticky, W1C).
  - idx2 ID: RO constant 0x4D41_594F.
  - idx3 INFO: RO; [7:0] NUM_WR_REGS, [15:8] NUM_RD_REGS.
  - idx4..4+NUM_WR_REGS-1: RW parameter registers.
  - Next NUM_RD_REGS indices: RO results.
  - Higher indices: unmapped.
- Reset: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, all registers 0, core_start/core_soft_rst/irq 0.
- Write path:
  - AWREADY high while no address is held and BVALID is low; WREADY likewise for data. AW and W may arrive in either order or the same cycle.
  - Commit in the cycle after both are held. BVALID rises in that same commit cycle and holds until BREADY. The held address/data clear on the B handshake.
- WSTRB applies per byte to RW registers. For CTRL, a pulse bit fires only if WSTRB[0]=1.
- BRESP:
  - OKAY for mapped addresses, including writes to RO registers (write ignored).
  - SLVERR (2'b10) for unmapped addresses (no state change).
- START:
  - Written 1 while BUSY=0: core_start asserts for exactly one cycle, in the cycle after commit.
  - Written 1 while BUSY=1: no pulse; START_ERR set.
- DONE is set by core_done. If a core_done set and a W1C clear hit DONE in the same cycle, the set wins. The same rule applies to START_ERR.
- SOFT_RST pulses core_soft_rst for one cycle. It does not clear the bank.
- irq = IRQ_EN & DONE, registered (one cycle after DONE sets).
- Read path:
  - ARREADY high while RVALID is low.
  - RDATA/RRESP are registered from the AR handshake; RVALID rises the following cycle and holds until RREADY.
  - Unmapped reads return 0 with SLVERR.
  - rd_regs_i is sampled at the AR handshake.
- Only one read and one write are outstanding. The read and write paths are fully independent and may complete in the same cycle.
- Asynchronous ARESETN mid-transaction aborts it: VALIDs drop immediately and the bank returns to reset values. No response is owed.

Decomposition:
- Package axi_lite_mayo_pkg: register index constants, CTRL/STATUS bit positions, ID value, RESP_OKAY/RESP_SLVERR localparams.
- Sub-module axi_lite_mayo_wr_ctrl: AW/W capture, commit strobe, B channel. It emits {commit, word_idx, wdata, wstrb} to the top-level register file.

Test Plan:
- Reset, then read idx2 and idx3 (defaults) -> 0x4D41594F and 0x00000808, both OKAY.
- Write 0x00000001..0x00000008 to idx4..11, issuing W two cycles before AW -> all BRESP OKAY; read back equal; wr_regs_o[31:0] = 0x00000001.
- Write 0xAABBCCDD to idx4 with WSTRB=4'b0101 over 0x00000001 -> read 0x00BB00DD.
- Set IRQ_EN=1, write START (CTRL=0x5) with core_busy=0 -> core_start high exactly one cycle. Then drive core_done -> STATUS=0x2; irq high one cycle later. Write 0x2 to STATUS -> DONE=0, irq=0.
- With core_busy=1, write CTRL=0x1 -> no core_start; STATUS reads 0x5. On the same cycle core_done=1 and a W1C of DONE -> DONE reads 1.
- Write and read idx 0x7F (unmapped) -> BRESP=SLVERR, RDATA=0 with RRESP=SLVERR, no register changes; hold RREADY low 5 cycles -> RVALID/RDATA stable.
